sprite_rom_arb: RTL

Round-robin arbiter that shares one synchronous sprite ROM read port among the four layer renderers (me, bullet, enemy, bonus) feeding the display compositor. Each renderer issues pixel-fetch requests over a valid/ready handshake. The arbiter forwards one address per cycle to the ROM. It then routes the returned `{rgb, alpha}` word back to the originating renderer with a per-requester valid pulse. It sits in the `clk_vga` domain between the renderers and the ROM.

---
 rtl/sprite_rom_arb.sv | 97 +++++++++
 1 files changed

// File: rtl/sprite_rom_arb.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among the
// layer renderers; returns each ROM word to its requester with a valid pulse.
module sprite_rom_arb #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 13,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk_vga,
    input  logic                      rst_n,
    input  logic                      freeze_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*ADDR_W-1:0]   addr_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic                      rom_en_o,
    output logic [ADDR_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]         rom_data_i,
    output logic [N_REQ-1:0]          rd_valid_o,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic                      busy_o
);

    localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DEPTH = ROM_LAT + 1;
    localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

    logic [IDW-1:0]            last_q, last_d;
    logic [IDW-1:0]            gnt_idx;
    logic                      xfer;
    logic [ADDR_W-1:0]         rom_addr_q, rom_addr_d;
    logic [DEPTH-1:0]          vld_q, vld_d;
    logic [DEPTH-1:0][IDW-1:0] id_q, id_d;
    logic [DATA_W-1:0]         rd_data_q, rd_data_d;

    // Search upward from the slot after the last winner; reset and freeze
    // suppress the grant so no transfer can happen.
    always_comb begin
        int idx;
        gnt_o   = '0;
        gnt_idx = last_q;
        xfer    = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (!xfer && req_i[idx]) begin
                xfer    = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
        if (!rst_n || freeze_i) begin
            xfer = 1'b0;
        end
        if (xfer) begin
            gnt_o[gnt_idx] = 1'b1;
        end
        last_d = xfer ? gnt_idx : last_q;
    end

    // Stage 0 of the tag pipeline doubles as the ROM enable; the tail lines
    // up with the cycle in which the ROM word is valid.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (xfer) begin
            rom_addr_d = addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
        end
        vld_d = {vld_q[DEPTH-2:0], xfer};
        id_d  = {id_q[DEPTH-2:0], gnt_idx};

        rd_valid_o = '0;
        if (vld_q[ROM_LAT]) begin
            rd_valid_o[id_q[ROM_LAT]] = 1'b1;
        end
        rd_data_d = vld_q[ROM_LAT] ? rom_data_i : rd_data_q;
        rd_data_o = rd_data_d;
    end

    assign rom_en_o   = vld_q[0];
    assign rom_addr_o = rom_addr_q;
    assign busy_o     = |vld_q;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= LAST_RST;
            rom_addr_q <= '0;
            vld_q      <= '0;
            id_q       <= '0;
            rd_data_q  <= '0;
        end else begin
            last_q     <= last_d;
            rom_addr_q <= rom_addr_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule
